// File: rtl/fu_pkg.sv
// Shared types and the ALU datapath function for the FU/CDB block.
package fu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADC   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SBC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_PASSB = 4'd9
    } fu_op_e;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    localparam int ROBID_NONE = 0;

    // Queue entries carry the widest supported ROB tag; the top zero-extends.
    localparam int ROBW_MAX = 8;

    typedef struct packed {
        logic [ROBW_MAX-1:0] robid;
        logic [7:0]          val;
        logic [7:0]          flag;
        logic [7:0]          wbs;
    } fu_result_t;

    // Returns {flags, result}. Undefined opcodes fall through to PASS A.
    function automatic logic [15:0] fu_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] wide;
        logic [7:0] r;
        logic [7:0] f;
        logic [2:0] sh;
        logic       c;
        logic       v;
        wide = '0;
        r    = a;
        f    = '0;
        sh   = b[2:0];
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide = {1'b0, a} + {1'b0, b} + {8'b0, cin & (op == OP_ADC)};
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB, OP_SBC: begin
                wide = {1'b0, a} - {1'b0, b} - {8'b0, cin & (op == OP_SBC)};
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SHL: begin
                wide = {1'b0, a} << sh;
                r    = wide[7:0];
                c    = (sh != 3'd0) & wide[8];
            end
            OP_SHR: begin
                r = a >> sh;
                c = (sh != 3'd0) & a[sh - 3'd1];
            end
            OP_PASSB: r = b;
            default:  r = a;
        endcase
        f[FLG_Z] = (r == 8'd0);
        f[FLG_N] = r[7];
        f[FLG_C] = c;
        f[FLG_V] = v;
        return {f, r};
    endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// In-order result queue; push and pop on the same edge are both honoured, even when full.
module fu_result_fifo
    import fu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fu_result_t    din_i,
    input  logic          pop_i,
    output fu_result_t    head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fu_result_t    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and count next-state; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/fu_alu_cdb.sv
// FU end of the RS issue chain: one-stage ALU, result queue, CDB broadcast under grant.
module fu_alu_cdb
    import fu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROBW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            futransmit,
    input  logic [7:0]      operandin,
    input  logic [7:0]      wbsin,
    input  logic [1:0][7:0] depvalsin,
    input  logic [7:0]      flagin,
    input  logic [ROBW-1:0] robidin,
    output logic            fuclaimedout,
    output logic            cdb_req,
    input  logic            cdb_grant,
    output logic            cdb_valid,
    output logic [ROBW-1:0] cdb_robid,
    output logic [7:0]      cdb_val,
    output logic [7:0]      cdb_flag,
    output logic [7:0]      cdb_wbs,
    output logic            err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            stage_valid_q, stage_valid_d;
    logic [3:0]      stage_op_q, stage_op_d;
    logic [7:0]      stage_a_q, stage_a_d;
    logic [7:0]      stage_b_q, stage_b_d;
    logic            stage_cin_q, stage_cin_d;
    logic [ROBW-1:0] stage_robid_q, stage_robid_d;
    logic [7:0]      stage_wbs_q, stage_wbs_d;
    logic            err_q, err_d;

    logic [15:0]     alu_out;
    fu_result_t      res;
    fu_result_t      head;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   occupancy;
    logic            fifo_empty;
    logic            fifo_full;
    logic            tag_none;
    logic            accept;
    logic            unused_bits;

    // Room is judged from registered state only; a pop this cycle does not free a slot early.
    assign occupancy    = fifo_count + CW'(stage_valid_q);
    assign fuclaimedout = (occupancy == CW'(DEPTH));
    assign tag_none     = (robidin == ROBW'(ROBID_NONE));
    assign accept       = futransmit & ~fuclaimedout & ~tag_none;

    assign alu_out   = fu_alu(stage_op_q, stage_a_q, stage_b_q, stage_cin_q);
    assign res.robid = ROBW_MAX'(stage_robid_q);
    assign res.val   = alu_out[7:0];
    assign res.flag  = alu_out[15:8];
    assign res.wbs   = stage_wbs_q;

    assign cdb_req   = ~fifo_empty;
    assign cdb_valid = cdb_req & cdb_grant;
    assign cdb_robid = cdb_valid ? head.robid[ROBW-1:0] : '0;
    assign cdb_val   = cdb_valid ? head.val  : '0;
    assign cdb_flag  = cdb_valid ? head.flag : '0;
    assign cdb_wbs   = cdb_valid ? head.wbs  : '0;
    assign err       = err_q;

    assign unused_bits = ^{operandin[7:4], flagin[7:3], flagin[1:0], head.robid, fifo_full};

    // Execute-stage capture and sticky error next-state.
    always_comb begin
        stage_valid_d = accept;
        stage_op_d    = stage_op_q;
        stage_a_d     = stage_a_q;
        stage_b_d     = stage_b_q;
        stage_cin_d   = stage_cin_q;
        stage_robid_d = stage_robid_q;
        stage_wbs_d   = stage_wbs_q;
        if (accept) begin
            stage_op_d    = operandin[3:0];
            stage_a_d     = depvalsin[0];
            stage_b_d     = depvalsin[1];
            stage_cin_d   = flagin[FLG_C];
            stage_robid_d = robidin;
            stage_wbs_d   = wbsin;
        end
        err_d = err_q | (futransmit & (fuclaimedout | tag_none));
    end

    // Execute-stage and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_op_q    <= '0;
            stage_a_q     <= '0;
            stage_b_q     <= '0;
            stage_cin_q   <= 1'b0;
            stage_robid_q <= '0;
            stage_wbs_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_op_q    <= stage_op_d;
            stage_a_q     <= stage_a_d;
            stage_b_q     <= stage_b_d;
            stage_cin_q   <= stage_cin_d;
            stage_robid_q <= stage_robid_d;
            stage_wbs_q   <= stage_wbs_d;
            err_q         <= err_d;
        end
    end

    fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stage_valid_q),
        .din_i   (res),
        .pop_i   (cdb_valid),
        .head_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
